// File: rtl/gsim_pkg.sv
// Shared widths, FSM encoding and saturation helper for the Gauss-Seidel feeder.
package gsim_pkg;

  localparam int unsigned N    = 16;
  localparam int unsigned XW   = 32;
  localparam int unsigned BW   = 16;
  localparam int unsigned PW   = 38;
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned NOPS = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_t;

  // Clamp a wide PE result into the signed XW-bit solution range.
  function automatic logic [XW-1:0] sat_x(input logic [PW-1:0] v);
    logic [PW-XW:0] top;
    top = v[PW-1:XW-1];
    if ((top == '0) || (top == '1)) begin
      return v[XW-1:0];
    end else if (v[PW-1]) begin
      return {1'b1, {(XW-1){1'b0}}};
    end else begin
      return {1'b0, {(XW-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/gsim_window.sv
// Neighbour operand selection around the row being issued; out-of-range taps read zero.
module gsim_window
  import gsim_pkg::*;
(
  input  logic [XW-1:0] x   [N],
  input  logic [IW-1:0] row,
  output logic [XW-1:0] ops [NOPS]
);

  // Tap order matches pe_in_1..pe_in_6.
  localparam int OFFS [NOPS] = '{3, -3, 2, -2, 1, -1};

  // Pick each neighbour, zeroing taps that fall off either end of the vector.
  always_comb begin
    int r;
    r = 0;
    for (int k = 0; k < int'(NOPS); k++) begin
      r      = int'(row) + OFFS[k];
      ops[k] = '0;
      if ((r >= 0) && (r < int'(N))) begin
        ops[k] = x[IW'(r)];
      end
    end
  end

endmodule

// File: rtl/gsim_feeder.sv
// Gauss-Seidel operand feeder: loads b, sweeps rows through an external PE, streams x out.
module gsim_feeder
  import gsim_pkg::*;
#(
  parameter int unsigned ITER   = 8,
  parameter int unsigned PE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 b_in_valid,
  output logic                 b_in_ready,
  input  logic signed [BW-1:0] b_in,
  output logic signed [XW-1:0] pe_in_1,
  output logic signed [XW-1:0] pe_in_2,
  output logic signed [XW-1:0] pe_in_3,
  output logic signed [XW-1:0] pe_in_4,
  output logic signed [XW-1:0] pe_in_5,
  output logic signed [XW-1:0] pe_in_6,
  output logic signed [BW-1:0] pe_b,
  input  logic signed [PW-1:0] pe_out,
  output logic                 x_out_valid,
  input  logic                 x_out_ready,
  output logic signed [XW-1:0] x_out,
  output logic [IW-1:0]        x_out_idx,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(ITER + 1);
  localparam int unsigned WW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic signed [BW-1:0] B_DIV = BW'(20);

  state_t state, state_nx;

  logic [BW-1:0] b_mem  [N];
  logic [XW-1:0] x_mem  [N];
  logic [XW-1:0] x_view [N];
  logic [XW-1:0] ops    [NOPS];

  logic [IW-1:0] row, load_idx, issue_row, load_widx, out_nxt;
  logic [SW-1:0] sweep;
  logic [WW-1:0] wait_cnt;

  logic                 b_acc, x_acc, wait_last, row_last, sweep_last, load_last, out_last;
  logic                 x_we;
  logic [IW-1:0]        x_widx;
  logic [XW-1:0]        x_wdata;
  logic signed [BW-1:0] b_quot;

  assign b_acc      = b_in_valid && b_in_ready;
  assign x_acc      = (state == ST_OUT) && x_out_valid && x_out_ready;
  assign wait_last  = (wait_cnt == WW'(PE_LAT - 1));
  assign row_last   = (row == IW'(N - 1));
  assign sweep_last = (sweep == SW'(ITER - 1));
  assign load_last  = (load_idx == IW'(N - 1));
  assign out_last   = (x_out_idx == IW'(N - 1));
  assign load_widx  = (state == ST_IDLE) ? '0 : load_idx;
  assign out_nxt    = x_out_idx + IW'(1);
  assign b_quot     = b_in / B_DIV;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state, x write port (load seed or PE write-back) and next issued row.
  always_comb begin
    state_nx  = state;
    x_we      = 1'b0;
    x_widx    = '0;
    x_wdata   = '0;
    issue_row = '0;
    unique case (state)
      ST_IDLE: begin
        if (b_acc) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (b_acc && load_last) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_last) begin
          x_we      = 1'b1;
          x_widx    = row;
          x_wdata   = sat_x(pe_out);
          issue_row = row_last ? '0 : row + IW'(1);
          state_nx  = (row_last && sweep_last) ? ST_OUT : ST_ISSUE;
        end
      end
      ST_OUT: begin
        if (x_acc && out_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (b_acc) begin
      x_we    = 1'b1;
      x_widx  = load_widx;
      x_wdata = {{(XW - BW){b_quot[BW-1]}}, b_quot};
    end
  end

  // x as it will look after this edge, so the next row sees the fresh write-back.
  always_comb begin
    x_view = x_mem;
    if (x_we) x_view[x_widx] = x_wdata;
  end

  gsim_window u_window (
    .x   (x_view),
    .row (issue_row),
    .ops (ops)
  );

  // Solution and right-hand-side storage; contents are fully rewritten by every load.
  always_ff @(posedge clk) begin
    if (!reset && x_we)  x_mem[x_widx]    <= x_wdata;
    if (!reset && b_acc) b_mem[load_widx] <= b_in;
  end

  // Counters, registered PE operands and output stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      row         <= '0;
      sweep       <= '0;
      wait_cnt    <= '0;
      load_idx    <= '0;
      pe_in_1     <= '0;
      pe_in_2     <= '0;
      pe_in_3     <= '0;
      pe_in_4     <= '0;
      pe_in_5     <= '0;
      pe_in_6     <= '0;
      pe_b        <= '0;
      x_out_valid <= 1'b0;
      x_out       <= '0;
      x_out_idx   <= '0;
      b_in_ready  <= 1'b1;
      busy        <= 1'b0;
    end else begin
      b_in_ready <= (state_nx == ST_IDLE) || (state_nx == ST_LOAD);
      busy       <= (state_nx != ST_IDLE);
      if (b_acc) load_idx <= load_widx + IW'(1);
      if (state == ST_ISSUE)     wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + WW'(1);
      if (state == ST_LOAD && state_nx == ST_ISSUE)     sweep <= '0;
      else if (state == ST_WAIT && wait_last && row_last) sweep <= sweep + SW'(1);
      if (state_nx == ST_ISSUE) begin
        row     <= issue_row;
        pe_in_1 <= ops[0];
        pe_in_2 <= ops[1];
        pe_in_3 <= ops[2];
        pe_in_4 <= ops[3];
        pe_in_5 <= ops[4];
        pe_in_6 <= ops[5];
        pe_b    <= b_mem[issue_row];
      end
      if (state != ST_OUT && state_nx == ST_OUT) begin
        x_out_valid <= 1'b1;
        x_out       <= x_view[0];
        x_out_idx   <= '0;
      end else if (x_acc) begin
        if (out_last) begin
          x_out_valid <= 1'b0;
        end else begin
          x_out_idx <= out_nxt;
          x_out     <= x_mem[out_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_gsim_feeder.sv
// Scoreboard bench for gsim_feeder: array-level Gauss-Seidel reference, behavioural PE.
module tb_gsim_feeder;
  import gsim_pkg::*;

  localparam int unsigned T_ITER = 1;
  localparam int unsigned T_LAT  = 1;
  localparam longint XMAX = 64'sh7FFFFFFF;
  localparam longint XMIN = -XMAX - 1;

  typedef logic signed [BW-1:0] bvec_t [N];
  typedef longint xvec_t [N];
  typedef struct {
    int            idx;
    logic [XW-1:0] val;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 b_in_valid = 1'b0;
  logic                 b_in_ready;
  logic signed [BW-1:0] b_in = '0;
  logic signed [XW-1:0] pe_in_1, pe_in_2, pe_in_3, pe_in_4, pe_in_5, pe_in_6;
  logic signed [BW-1:0] pe_b;
  logic signed [PW-1:0] pe_out = '0;
  logic                 x_out_valid;
  logic                 x_out_ready = 1'b0;
  logic signed [XW-1:0] x_out;
  logic [IW-1:0]        x_out_idx;
  logic                 busy;

  int     n_tests = 0;
  int     n_fail  = 0;
  exp_t   sb[$];
  int     pe_mode = 0;
  longint pe_const = 0;

  gsim_feeder #(.ITER(T_ITER), .PE_LAT(T_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .b_in_valid  (b_in_valid),
    .b_in_ready  (b_in_ready),
    .b_in        (b_in),
    .pe_in_1     (pe_in_1),
    .pe_in_2     (pe_in_2),
    .pe_in_3     (pe_in_3),
    .pe_in_4     (pe_in_4),
    .pe_in_5     (pe_in_5),
    .pe_in_6     (pe_in_6),
    .pe_b        (pe_b),
    .pe_out      (pe_out),
    .x_out_valid (x_out_valid),
    .x_out_ready (x_out_ready),
    .x_out       (x_out),
    .x_out_idx   (x_out_idx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Asymmetric weights so a swapped operand changes the answer.
  function automatic longint pe_f(input longint b, input longint i1, input longint i2,
                                  input longint i3, input longint i4, input longint i5,
                                  input longint i6);
    return (b + 3 * i1 + i2 + 2 * i3 - i4 + 5 * i5 - 2 * i6) / 20;
  endfunction

  // One-cycle PE: result visible the cycle after operands are presented.
  always @(posedge clk) begin
    if (pe_mode != 0) pe_out <= PW'(pe_const);
    else pe_out <= PW'(pe_f(longint'(pe_b), longint'(pe_in_1), longint'(pe_in_2),
                            longint'(pe_in_3), longint'(pe_in_4), longint'(pe_in_5),
                            longint'(pe_in_6)));
  end

  function automatic longint sat(input longint v);
    if (v > XMAX) return XMAX;
    if (v < XMIN) return XMIN;
    return v;
  endfunction

  function automatic longint xa(input xvec_t x, input int r);
    return ((r >= 0) && (r < int'(N))) ? x[r] : 0;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference solve: seed x=b/20, then in-place row sweeps, then queue the N results.
  task automatic push_model(input bvec_t bv, input int mode, input longint cval);
    xvec_t  x;
    longint v;
    exp_t   e;
    for (int j = 0; j < int'(N); j++) x[j] = longint'(bv[j]) / 20;
    for (int s = 0; s < int'(T_ITER); s++) begin
      for (int i = 0; i < int'(N); i++) begin
        v = (mode != 0) ? cval
            : pe_f(longint'(bv[i]), xa(x, i + 3), xa(x, i - 3), xa(x, i + 2),
                   xa(x, i - 2), xa(x, i + 1), xa(x, i - 1));
        x[i] = sat(v);
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      e.idx = j;
      e.val = XW'(x[j]);
      sb.push_back(e);
    end
  endtask

  // Output monitor: every accepted x beat is popped and compared.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && x_out_valid && x_out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: idx %0d value %0d, scoreboard empty", x_out_idx, x_out);
        end else begin
          e = sb.pop_front();
          check("out_idx", longint'(x_out_idx), longint'(e.idx));
          check("out_val", longint'(x_out), longint'($signed(e.val)));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pe_in_1"}, longint'(pe_in_1), 0);
    check({tag, "_pe_in_2"}, longint'(pe_in_2), 0);
    check({tag, "_pe_in_3"}, longint'(pe_in_3), 0);
    check({tag, "_pe_in_4"}, longint'(pe_in_4), 0);
    check({tag, "_pe_in_5"}, longint'(pe_in_5), 0);
    check({tag, "_pe_in_6"}, longint'(pe_in_6), 0);
    check({tag, "_pe_b"}, longint'(pe_b), 0);
    check({tag, "_x_out"}, longint'(x_out), 0);
    check({tag, "_x_out_idx"}, longint'(x_out_idx), 0);
    check({tag, "_x_out_valid"}, longint'(x_out_valid), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_b_in_ready"}, longint'(b_in_ready), 1);
  endtask

  // Stream b in; optional random valid gaps. Returns in the first ISSUE cycle.
  task automatic load(input bvec_t bv, input bit toggle);
    int j;
    int guard;
    bit v;
    bit rdy;
    j = 0;
    guard = 0;
    while (j < int'(N) && guard < 400) begin
      v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      b_in_valid = v;
      b_in = v ? bv[j] : BW'($urandom);
      rdy = b_in_ready;
      tick();
      if (v && rdy) j++;
      guard++;
    end
    b_in_valid = 1'b0;
    if (j < int'(N)) check("load_timeout", longint'(j), longint'(N));
  endtask

  task automatic run(input bvec_t bv, input int mode, input longint cval, input bit toggle,
                     input bit second, input bit stall, input int abort_row);
    int                   cyc;
    int                   guard;
    bit                   stalled;
    logic signed [XW-1:0] held;
    pe_mode = mode;
    pe_const = cval;
    x_out_ready = 1'b1;
    if (abort_row < 0) push_model(bv, mode, cval);
    load(bv, toggle);
    cyc = 1;
    check("issue0_pe_b", longint'(pe_b), longint'(bv[0]));
    check("issue0_pe_in_1", longint'(pe_in_1), longint'(bv[3]) / 20);
    check("issue0_pe_in_3", longint'(pe_in_3), longint'(bv[2]) / 20);
    check("issue0_pe_in_5", longint'(pe_in_5), longint'(bv[1]) / 20);
    check("issue0_pe_in_2", longint'(pe_in_2), 0);
    check("issue0_pe_in_4", longint'(pe_in_4), 0);
    check("issue0_pe_in_6", longint'(pe_in_6), 0);
    check("ready_low_busy", longint'(b_in_ready), 0);
    b_in_valid = 1'b1;
    b_in = BW'($urandom);
    if (second) begin
      tick();
      tick();
      cyc += 2;
      check("issue1_pe_b", longint'(pe_b), longint'(bv[1]));
      check("issue1_pe_in_5", longint'(pe_in_5), longint'(bv[2]) / 20);
      check("issue1_pe_in_6", longint'(pe_in_6), sat(cval));
    end
    if (abort_row >= 0) begin
      repeat (2 * abort_row) tick();
      check("abort_row_pe_b", longint'(pe_b), longint'(bv[abort_row]));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      b_in_valid = 1'b0;
      check_reset_state("abort");
      return;
    end
    while (!x_out_valid && cyc < 2000) begin
      tick();
      cyc++;
    end
    b_in_valid = 1'b0;
    check("latency", longint'(cyc), longint'(N * T_ITER * (T_LAT + 1) + 1));
    stalled = 1'b0;
    guard = 0;
    while (busy && guard < 500) begin
      if (stall && !stalled && x_out_valid && x_out_idx == IW'(3)) begin
        x_out_ready = 1'b0;
        held = x_out;
        repeat (5) begin
          tick();
          check("stall_idx", longint'(x_out_idx), 3);
          check("stall_val", longint'(x_out), longint'(held));
          check("stall_valid", longint'(x_out_valid), 1);
        end
        x_out_ready = 1'b1;
        stalled = 1'b1;
      end
      tick();
      guard++;
    end
    check("done_idle", longint'(busy), 0);
    check("done_valid_low", longint'(x_out_valid), 0);
    check("sb_drained", longint'(sb.size()), 0);
    if (stall) check("stall_seen", longint'(stalled), 1);
    sb.delete();
  endtask

  initial begin : stim
    bvec_t bv;
    bvec_t bkeep;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");

    // Directed operand map with a constant PE result of 7.
    for (int j = 0; j < int'(N); j++) bv[j] = BW'(20 * (j + 1));
    run(bv, 1, 7, 1'b0, 1'b1, 1'b0, -1);

    // Saturation high.
    for (int j = 0; j < int'(N); j++) bv[j] = BW'($urandom);
    run(bv, 1, longint'(1) <<< 35, 1'b0, 1'b0, 1'b0, -1);

    // Saturation low, plus truncation of a negative seed.
    for (int j = 0; j < int'(N); j++) bv[j] = BW'($urandom);
    bv[3] = -16'sd41;
    run(bv, 1, -(longint'(1) <<< 35), 1'b0, 1'b0, 1'b0, -1);
    check("round_neg41_seed", longint'(bv[3]) / 20, -2);

    // Randomized Gauss-Seidel solves, gappy input, one with output backpressure.
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < int'(N); j++) bv[j] = BW'($urandom);
      run(bv, 0, 0, 1'b1, 1'b0, (t == 1), -1);
    end

    // Clean run, reset at row 7, then a full reload of the same vector.
    for (int j = 0; j < int'(N); j++) bkeep[j] = BW'($urandom);
    run(bkeep, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    run(bkeep, 0, 0, 1'b1, 1'b0, 1'b0, 7);
    run(bkeep, 0, 0, 1'b1, 1'b0, 1'b0, -1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gsim_feeder.md
GSIM_FEEDER -- requirements
Module: gsim_feeder

Interface
REQ-001 Parameters: N=16, matrix order; ITER=8, sweeps per solve; PE_LAT=1, PE cycles from operand issue to valid out.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 b_in_valid / b_in_ready / b_in  in / out / in  1 / 1 / 16  signed right-hand-side load stream, element 0 first.
REQ-005 pe_in_1..pe_in_6  out  32 each  signed neighbour operands to PE.
REQ-006 pe_b  out  16  signed b of row under update.
REQ-007 pe_out  in  38  signed PE result.
REQ-008 x_out_valid / x_out_ready / x_out / x_out_idx  out / in / out / out  1 / 1 / 32 / 4  signed solution stream with element index.
REQ-009 busy  out  1  high in any state except IDLE.

Function
REQ-010 FSM states IDLE, LOAD, ISSUE, WAIT, OUT; transfer on any stream only when valid&&ready on the same edge.
REQ-011 b_in_ready = 1 in IDLE and LOAD only; first accepted beat in IDLE moves to LOAD; N-th accepted beat moves to ISSUE with row i=0, sweep=0.
REQ-012 On accepting b_j: b_mem[j]=b_j; x_mem[j]=b_j/20, truncated toward zero, sign-extended to 32 bits.
REQ-013 ISSUE (one cycle) for row i drives pe_in_1=x[i+3], pe_in_2=x[i-3], pe_in_3=x[i+2], pe_in_4=x[i-2], pe_in_5=x[i+1], pe_in_6=x[i-1], pe_b=b[i]; any index outside 0..N-1 drives 0.
REQ-014 Operands are registered outputs and hold their values until the next ISSUE.
REQ-015 WAIT lasts exactly PE_LAT cycles; on its last cycle pe_out is sampled and written to x_mem[i], saturated to [-2^31, 2^31-1].
REQ-016 Gauss-Seidel ordering: ISSUE of row i+1 occurs on the cycle after write-back of row i and reads the updated x[i]; per-row period is PE_LAT+1 cycles.
REQ-017 After row N-1: i wraps to 0 and sweep increments; when sweep reaches ITER, go to OUT instead of ISSUE.
REQ-018 OUT presents x_mem[k], idx k, k=0..N-1 with x_out_valid=1; x_out, x_out_idx stay stable while !x_out_ready; after beat N-1 is accepted, x_out_valid=0 on the next cycle and FSM returns to IDLE.
REQ-019 b_in_valid outside IDLE/LOAD is ignored; x_out_ready outside OUT is ignored.

Reset
REQ-020 Reset from any state, mid-load or mid-sweep included, forces IDLE and clears row, sweep and output counters.
REQ-021 Reset values: all pe_in_*, pe_b, x_out, x_out_idx = 0; x_out_valid=0; busy=0; b_in_ready=1 on the first cycle after reset.
REQ-022 b_mem and x_mem need not be cleared; every entry is overwritten by the next load.

Structure
REQ-023 Package gsim_pkg holds N, XW=32, BW=16, PW=38, the FSM state enum, and the saturation function.
REQ-024 One sub-module gsim_window: combinational neighbour selection with out-of-range zeroing per REQ-013; all other logic stays in gsim_feeder.

Verification
REQ-025 Operand map: load b_j=20*(j+1); first ISSUE -> pe_b=20, pe_in_1=4, pe_in_3=3, pe_in_5=2, pe_in_2/4/6=0; second ISSUE, PE model out=7 for row 0 -> pe_in_6=7, pe_in_5=3, pe_b=40.
REQ-026 Timing: PE_LAT=1, ITER=1, x_out_ready=1 -> first x_out_valid exactly 2N+1=33 cycles after the cycle accepting the last b beat.
REQ-027 Saturation and rounding: pe_out=2^35 -> x=0x7FFFFFFF; pe_out=-2^35 -> x=0x80000000; b=-41 -> initial x=-2.
REQ-028 Backpressure: toggle b_in_valid and hold x_out_ready=0 for 5 cycles at k=3 -> no lost or duplicated beat; x_out_idx=3 stable throughout the stall.
REQ-029 Reset mid-sweep at row 7 -> next cycle IDLE, busy=0, all outputs 0; a full reload then produces results identical to a clean run.
